data_bus_arbiter: RTL and testbench

- Two-master arbiter for the shared data bus (address, 2-bit mode, 32-bit data) used by data memory and peripherals.
- Master 0 is the CPU core's data port; master 1 is a secondary master (DMA or debug).
- Grants the bus to one master at a time with bounded bursts and round-robin fairness.
- Inserts a one-cycle turnaround on owner change so write-data drivers never overlap.

---
 rtl/data_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_data_bus_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter for the shared data bus. Master 0 is the CPU data port,
// master 1 is a secondary master. Ownership is granted in bounded bursts with
// round-robin tie-breaking, and a one-cycle turnaround separates owners so
// write-data drivers never overlap.
//
// state  | meaning
// IDLE   | no owner; bus quiet; also serves as turnaround before a new grant
// OWN0   | master 0 owns the bus, bus driven from m0_*
// OWN1   | master 1 owns the bus, bus driven from m1_*
// TURN   | one quiet cycle between two different owners
module data_bus_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_mode,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_mode,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] data_bus_addr,
  output logic [1:0]        data_bus_mode,
  output logic [DATA_W-1:0] data_bus_wdata,
  output logic              data_bus_wdata_oe,
  input  logic [DATA_W-1:0] data_bus_rdata,
  output logic              owner,
  output logic              busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  // Burst counter saturates here; reaching it under contention forces a handover.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] burst_cnt;
  logic       last_owner;
  logic       target;

  logic       own_idx;
  logic       in_own;
  logic       cur_req;
  logic       oth_req;
  logic       enter_own;
  logic       enter_idx;
  logic       to_turn;

  logic [1:0] sel_mode;
  logic       sel_req;

  assign in_own  = (state == S_OWN0) || (state == S_OWN1);
  assign own_idx = (state == S_OWN1);
  assign cur_req = own_idx ? m1_req : m0_req;
  assign oth_req = own_idx ? m0_req : m1_req;

  // Next-state decision and the grant it implies.
  always_comb begin
    state_nxt = state;
    enter_own = 1'b0;
    enter_idx = 1'b0;
    to_turn   = 1'b0;
    case (state)
      S_IDLE: begin
        if (m0_req && m1_req) begin
          enter_own = 1'b1;
          enter_idx = ~last_owner;
        end else if (m0_req) begin
          enter_own = 1'b1;
          enter_idx = 1'b0;
        end else if (m1_req) begin
          enter_own = 1'b1;
          enter_idx = 1'b1;
        end
      end
      S_OWN0, S_OWN1: begin
        if (!cur_req && !oth_req) begin
          state_nxt = S_IDLE;
        end else if (!cur_req) begin
          to_turn = 1'b1;
        end else if (oth_req && (burst_cnt == BURST_LAST)) begin
          to_turn = 1'b1;
        end
      end
      default: begin
        // TURN: prefer the master we were handing over to, else take whoever asks.
        if (target ? m1_req : m0_req) begin
          enter_own = 1'b1;
          enter_idx = target;
        end else if (target ? m0_req : m1_req) begin
          enter_own = 1'b1;
          enter_idx = ~target;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
    if (to_turn) begin
      state_nxt = S_TURN;
    end
    if (enter_own) begin
      state_nxt = enter_idx ? S_OWN1 : S_OWN0;
    end
  end

  // State, burst counter, last owner and turnaround target registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      burst_cnt  <= 8'd0;
      last_owner <= 1'b1;
      target     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (enter_own) begin
        last_owner <= enter_idx;
        burst_cnt  <= 8'd0;
      end else if (in_own && cur_req && (burst_cnt != BURST_LAST)) begin
        burst_cnt <= burst_cnt + 8'd1;
      end
      if (to_turn) begin
        target <= ~own_idx;
      end
    end
  end

  assign sel_mode = own_idx ? m1_mode : m0_mode;
  assign sel_req  = cur_req;

  // Bus drive: owner's signals pass straight through; quiet otherwise.
  always_comb begin
    data_bus_addr     = '0;
    data_bus_mode     = 2'b00;
    data_bus_wdata    = '0;
    data_bus_wdata_oe = 1'b0;
    if (in_own) begin
      data_bus_addr     = own_idx ? m1_addr : m0_addr;
      data_bus_wdata    = own_idx ? m1_wdata : m0_wdata;
      data_bus_mode     = (sel_mode == 2'b11) ? 2'b00 : sel_mode;
      data_bus_wdata_oe = sel_req && (sel_mode == 2'b10);
    end
  end

  assign m0_gnt   = (state == S_OWN0);
  assign m1_gnt   = (state == S_OWN1);
  assign m0_rdata = m0_gnt ? data_bus_rdata : '0;
  assign m1_rdata = m1_gnt ? data_bus_rdata : '0;
  assign owner    = last_owner;
  assign busy     = (state != S_IDLE);

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: directed vector table, burst/alternation
// sequences, and randomized traffic against a behavioural model. Two DUT
// copies share the inputs: MAX_BURST=8 and MAX_BURST=1.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  md [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd;

  logic [1:0]  gnt    [2];
  logic [31:0] r0d    [2];
  logic [31:0] r1d    [2];
  logic [31:0] baddr  [2];
  logic [1:0]  bmode  [2];
  logic [31:0] bwdata [2];
  logic        oe     [2];
  logic        own_o  [2];
  logic        busy_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut8 (
    .clk(clk), .reset(rst),
    .m0_req(req[0]), .m0_addr(ad[0]), .m0_mode(md[0]), .m0_wdata(wd[0]),
    .m0_gnt(gnt[0][0]), .m0_rdata(r0d[0]),
    .m1_req(req[1]), .m1_addr(ad[1]), .m1_mode(md[1]), .m1_wdata(wd[1]),
    .m1_gnt(gnt[0][1]), .m1_rdata(r1d[0]),
    .data_bus_addr(baddr[0]), .data_bus_mode(bmode[0]), .data_bus_wdata(bwdata[0]),
    .data_bus_wdata_oe(oe[0]), .data_bus_rdata(rd),
    .owner(own_o[0]), .busy(busy_o[0]));

  data_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(rst),
    .m0_req(req[0]), .m0_addr(ad[0]), .m0_mode(md[0]), .m0_wdata(wd[0]),
    .m0_gnt(gnt[1][0]), .m0_rdata(r0d[1]),
    .m1_req(req[1]), .m1_addr(ad[1]), .m1_mode(md[1]), .m1_wdata(wd[1]),
    .m1_gnt(gnt[1][1]), .m1_rdata(r1d[1]),
    .data_bus_addr(baddr[1]), .data_bus_mode(bmode[1]), .data_bus_wdata(bwdata[1]),
    .data_bus_wdata_oe(oe[1]), .data_bus_rdata(rd),
    .owner(own_o[1]), .busy(busy_o[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: owner as an integer (-1 = nobody), a turnaround flag,
  // and the number of request-holding cycles spent in the current tenure.
  int m_own   [2];
  bit m_turn  [2];
  int m_tgt   [2];
  int m_last  [2];
  int m_held  [2];
  int mb      [2] = '{8, 1};

  task automatic model_reset(input int k);
    m_own[k] = -1; m_turn[k] = 0; m_tgt[k] = 0; m_last[k] = 1; m_held[k] = 0;
  endtask

  task automatic model_grant(input int k, input int m);
    m_own[k] = m; m_last[k] = m; m_held[k] = 0; m_turn[k] = 0;
  endtask

  task automatic model_step(input int k);
    int i, j;
    if (rst) begin
      model_reset(k);
    end else if (m_turn[k]) begin
      m_turn[k] = 0;
      if (req[m_tgt[k]]) model_grant(k, m_tgt[k]);
      else if (req[1 - m_tgt[k]]) model_grant(k, 1 - m_tgt[k]);
      else m_own[k] = -1;
    end else if (m_own[k] < 0) begin
      if (req[0] && req[1]) model_grant(k, 1 - m_last[k]);
      else if (req[0]) model_grant(k, 0);
      else if (req[1]) model_grant(k, 1);
    end else begin
      i = m_own[k];
      j = 1 - i;
      if (!req[i] && !req[j]) begin
        m_own[k] = -1;
      end else if (!req[i] || (req[j] && m_held[k] >= mb[k] - 1)) begin
        m_own[k] = -1; m_turn[k] = 1; m_tgt[k] = j;
      end else begin
        m_held[k]++;
      end
    end
  endtask

  task automatic model_check(input int k);
    logic [1:0]  e_gnt;
    logic [1:0]  e_mode;
    logic [31:0] e_addr, e_wdata;
    logic        e_oe;
    int o;
    o = m_own[k];
    e_gnt = 2'b00; e_mode = 2'b00; e_addr = 0; e_wdata = 0; e_oe = 0;
    if (o >= 0) begin
      e_gnt[o] = 1'b1;
      e_addr   = ad[o];
      e_wdata  = wd[o];
      e_mode   = (md[o] == 2'b11) ? 2'b00 : md[o];
      e_oe     = req[o] && (md[o] == 2'b10);
    end
    chk($sformatf("rnd%0d gnt", k), 64'(gnt[k]), 64'(e_gnt));
    chk($sformatf("rnd%0d mode", k), 64'(bmode[k]), 64'(e_mode));
    chk($sformatf("rnd%0d addr", k), 64'(baddr[k]), 64'(e_addr));
    chk($sformatf("rnd%0d wdata", k), 64'(bwdata[k]), 64'(e_wdata));
    chk($sformatf("rnd%0d oe", k), 64'(oe[k]), 64'(e_oe));
    chk($sformatf("rnd%0d busy", k), 64'(busy_o[k]), 64'((o >= 0) || m_turn[k]));
    chk($sformatf("rnd%0d owner", k), 64'(own_o[k]), 64'(m_last[k]));
    chk($sformatf("rnd%0d rdata0", k), 64'(r0d[k]), 64'((o == 0) ? rd : 32'h0));
    chk($sformatf("rnd%0d rdata1", k), 64'(r1d[k]), 64'((o == 1) ? rd : 32'h0));
  endtask

  typedef struct {
    logic rst; logic r0; logic [1:0] md0; logic r1; logic [1:0] md1;
    logic g0; logic g1; logic [1:0] bmode; logic [31:0] baddr; logic [31:0] bwdata;
    logic oe; logic busy; logic [31:0] rd0; logic [31:0] rd1; logic owner;
  } vec_t;

  localparam logic [31:0] A0 = 32'h100, W0 = 32'hA0A0_0000;
  localparam logic [31:0] A1 = 32'h200, W1 = 32'hB1B1_0000;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;

  vec_t tbl [13];

  task automatic apply_reset();
    rst = 1'b1; req = 2'b00;
    md[0] = 0; md[1] = 0; ad[0] = 0; ad[1] = 0; wd[0] = 0; wd[1] = 0; rd = 0;
    repeat (2) @(posedge clk);
    model_reset(0); model_reset(1);
  endtask

  initial begin
    bit prev_oe [2];
    logic [1:0] prev_g [2];

    // rst r0 md0 r1 md1 | g0 g1 mode addr wdata oe busy rd0 rd1 owner
    tbl[0]  = '{1, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0,  0,  0, 0, 0,  0,  1};
    tbl[1]  = '{0, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0,  0,  0, 0, 0,  0,  1};
    tbl[2]  = '{0, 1, 2'b01, 0, 2'b00, 1, 0, 2'b01, A0, W0, 0, 1, DB, 0,  0};
    tbl[3]  = '{0, 0, 2'b00, 1, 2'b10, 1, 0, 2'b00, A0, W0, 0, 1, DB, 0,  0};
    tbl[4]  = '{0, 0, 2'b00, 1, 2'b10, 0, 0, 2'b00, 0,  0,  0, 1, 0,  0,  0};
    tbl[5]  = '{0, 0, 2'b00, 1, 2'b10, 0, 1, 2'b10, A1, W1, 1, 1, 0,  DB, 1};
    tbl[6]  = '{1, 0, 2'b00, 1, 2'b10, 0, 1, 2'b10, A1, W1, 1, 1, 0,  DB, 1};
    tbl[7]  = '{0, 1, 2'b01, 1, 2'b01, 0, 0, 2'b00, 0,  0,  0, 0, 0,  0,  1};
    tbl[8]  = '{0, 1, 2'b01, 1, 2'b01, 1, 0, 2'b01, A0, W0, 0, 1, DB, 0,  0};
    tbl[9]  = '{0, 0, 2'b00, 1, 2'b01, 1, 0, 2'b00, A0, W0, 0, 1, DB, 0,  0};
    tbl[10] = '{0, 1, 2'b01, 0, 2'b00, 0, 0, 2'b00, 0,  0,  0, 1, 0,  0,  0};
    tbl[11] = '{0, 1, 2'b11, 0, 2'b00, 1, 0, 2'b00, A0, W0, 0, 1, DB, 0,  0};
    tbl[12] = '{0, 1, 2'b10, 0, 2'b00, 1, 0, 2'b10, A0, W0, 1, 1, DB, 0,  0};

    // Directed table on the MAX_BURST=8 copy.
    apply_reset();
    for (int v = 0; v < 13; v++) begin
      @(negedge clk);
      rst = tbl[v].rst; req = {tbl[v].r1, tbl[v].r0};
      md[0] = tbl[v].md0; md[1] = tbl[v].md1;
      ad[0] = A0; ad[1] = A1; wd[0] = W0; wd[1] = W1; rd = DB;
      #1;
      chk($sformatf("v%0d gnt0", v), 64'(gnt[0][0]), 64'(tbl[v].g0));
      chk($sformatf("v%0d gnt1", v), 64'(gnt[0][1]), 64'(tbl[v].g1));
      chk($sformatf("v%0d mode", v), 64'(bmode[0]), 64'(tbl[v].bmode));
      chk($sformatf("v%0d addr", v), 64'(baddr[0]), 64'(tbl[v].baddr));
      chk($sformatf("v%0d wdata", v), 64'(bwdata[0]), 64'(tbl[v].bwdata));
      chk($sformatf("v%0d oe", v), 64'(oe[0]), 64'(tbl[v].oe));
      chk($sformatf("v%0d busy", v), 64'(busy_o[0]), 64'(tbl[v].busy));
      chk($sformatf("v%0d rdata0", v), 64'(r0d[0]), 64'(tbl[v].rd0));
      chk($sformatf("v%0d rdata1", v), 64'(r1d[0]), 64'(tbl[v].rd1));
      chk($sformatf("v%0d owner", v), 64'(own_o[0]), 64'(tbl[v].owner));
    end

    // Constant write contention: 8-cycle bursts (period 18) and strict
    // alternation with MAX_BURST=1 (period 4), one TURN between owners.
    apply_reset();
    @(negedge clk);
    rst = 0; req = 2'b11; md[0] = 2'b10; md[1] = 2'b10;
    for (int c = 0; c < 40; c++) begin
      logic [1:0] e8, e1;
      int p8, p1;
      #1;
      e8 = 2'b00; e1 = 2'b00;
      if (c > 0) begin
        p8 = (c - 1) % 18;
        p1 = (c - 1) % 4;
        if (p8 < 8) e8 = 2'b01; else if (p8 > 8 && p8 < 17) e8 = 2'b10;
        if (p1 == 0) e1 = 2'b01; else if (p1 == 2) e1 = 2'b10;
      end
      chk($sformatf("burst8 c%0d gnt", c), 64'(gnt[0]), 64'(e8));
      chk($sformatf("burst8 c%0d oe", c), 64'(oe[0]), 64'(e8 != 2'b00));
      chk($sformatf("alt1 c%0d gnt", c), 64'(gnt[1]), 64'(e1));
      chk($sformatf("alt1 c%0d oe", c), 64'(oe[1]), 64'(e1 != 2'b00));
      @(negedge clk);
    end

    // Reset during an OWN1 write: quiet next cycle, then a tie goes to m0.
    apply_reset();
    @(negedge clk);
    rst = 0; req = 2'b10; md[1] = 2'b10;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre-reset gnt1", 64'(gnt[0][1]), 64'(1));
    rst = 1;
    @(negedge clk);
    rst = 0; req = 2'b11; md[0] = 2'b01; md[1] = 2'b01;
    #1;
    chk("post-reset gnt", 64'(gnt[0]), 64'(0));
    chk("post-reset mode", 64'(bmode[0]), 64'(0));
    chk("post-reset oe", 64'(oe[0]), 64'(0));
    chk("post-reset busy", 64'(busy_o[0]), 64'(0));
    @(negedge clk);
    #1;
    chk("post-reset tie gnt", 64'(gnt[0]), 64'(2'b01));

    // Randomized traffic against the model, both copies.
    apply_reset();
    prev_oe[0] = 0; prev_oe[1] = 0; prev_g[0] = 0; prev_g[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 149) == 0);
      for (int m = 0; m < 2; m++) begin
        if ($urandom_range(0, 5) == 0) req[m] = ~req[m];
        md[m] = 2'($urandom_range(0, 3));
        ad[m] = $urandom;
        wd[m] = $urandom;
      end
      rd = $urandom;
      #1;
      for (int k = 0; k < 2; k++) begin
        model_check(k);
        if (oe[k] && prev_oe[k]) begin
          chk($sformatf("rnd%0d oe owner change", k), 64'(gnt[k]), 64'(prev_g[k]));
        end
        prev_oe[k] = oe[k];
        prev_g[k]  = gnt[k];
      end
      @(posedge clk);
      model_step(0);
      model_step(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
